// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode/state types and helpers for the sequential ALU
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings seen on the op port
    typedef enum logic [3:0] {
        OP_NOT = 4'h0,
        OP_AND = 4'h1,
        OP_OR  = 4'h2,
        OP_XOR = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SUB = 4'h6,
        OP_SBC = 4'h7,
        OP_INC = 4'h8,
        OP_DEC = 4'h9,
        OP_SHL = 4'hA,
        OP_SHR = 4'hB,
        OP_ROL = 4'hC,
        OP_ROR = 4'hD,
        OP_CMP = 4'hE,
        OP_NOP = 4'hF
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Shifts and rotates are the only ops that iterate
    function automatic logic is_shift(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational ALU datapath: logic, add/sub, compare and a
//                single-bit shift/rotate step, with full/half-word masking
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WORD_W = 20
) (
    input  op_e               i_op,
    input  logic              i_mode,
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    input  logic              i_shamt_zero,
    output logic [WORD_W-1:0] o_res,
    output logic              o_zero,
    output logic              o_sign,
    output logic              o_carry,
    output logic              o_carry_we,
    output logic              o_flags_we
);

    localparam int HALF_W = WORD_W / 2;

    logic [WORD_W-1:0] w_mask;
    logic [WORD_W-1:0] w_top;
    logic [WORD_W-1:0] w_aa;
    logic [WORD_W-1:0] w_bb;
    logic [WORD_W-1:0] w_ob;
    logic [WORD_W-1:0] w_shl;
    logic [WORD_W-1:0] w_shr;
    logic [WORD_W:0]   w_arith;
    logic              w_ci;
    logic              w_sub;
    logic              w_msb;
    logic              w_acarry;

    // Active-width mask; w_top marks bit AW-1 so sign/msb work in both modes
    assign w_mask = i_mode ? {WORD_W{1'b1}} : {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};
    assign w_top  = w_mask & ~(w_mask >> 1);
    assign w_aa   = i_a & w_mask;
    assign w_bb   = i_b & w_mask;
    assign w_msb  = |(w_aa & w_top);
    assign w_shl  = (w_aa << 1) & w_mask;
    assign w_shr  = w_aa >> 1;

    // One shared adder/subtractor; carry/borrow is taken from bit AW
    always_comb begin
        w_sub    = (i_op == OP_SUB) || (i_op == OP_SBC) || (i_op == OP_DEC) || (i_op == OP_CMP);
        w_ci     = ((i_op == OP_ADC) || (i_op == OP_SBC)) ? i_cin : 1'b0;
        w_ob     = ((i_op == OP_INC) || (i_op == OP_DEC)) ? WORD_W'(1) : w_bb;
        if (w_sub) begin
            w_arith = {1'b0, w_aa} - {1'b0, w_ob} - {{WORD_W{1'b0}}, w_ci};
        end else begin
            w_arith = {1'b0, w_aa} + {1'b0, w_ob} + {{WORD_W{1'b0}}, w_ci};
        end
        w_acarry = i_mode ? w_arith[WORD_W] : w_arith[HALF_W];
    end

    // Result and flag-update selection per opcode
    always_comb begin
        o_res      = w_aa;
        o_carry    = 1'b0;
        o_carry_we = 1'b0;
        o_flags_we = 1'b1;
        case (i_op)
            OP_NOT: o_res = ~w_aa & w_mask;
            OP_AND: o_res = w_aa & w_bb;
            OP_OR:  o_res = w_aa | w_bb;
            OP_XOR: o_res = w_aa ^ w_bb;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
                o_res      = w_arith[WORD_W-1:0] & w_mask;
                o_carry    = w_acarry;
                o_carry_we = 1'b1;
            end
            OP_SHL: if (!i_shamt_zero) begin
                o_res      = w_shl;
                o_carry    = w_msb;
                o_carry_we = 1'b1;
            end
            OP_SHR: if (!i_shamt_zero) begin
                o_res      = w_shr;
                o_carry    = w_aa[0];
                o_carry_we = 1'b1;
            end
            OP_ROL: if (!i_shamt_zero) begin
                o_res      = w_shl | {{(WORD_W-1){1'b0}}, w_msb};
                o_carry    = w_msb;
                o_carry_we = 1'b1;
            end
            OP_ROR: if (!i_shamt_zero) begin
                o_res      = w_shr | (w_aa[0] ? w_top : {WORD_W{1'b0}});
                o_carry    = w_aa[0];
                o_carry_we = 1'b1;
            end
            OP_CMP: o_res = w_aa;
            OP_NOP: o_flags_we = 1'b0;
            default: o_flags_we = 1'b0;
        endcase
        // CMP reports equality and unsigned a<b instead of result properties
        o_zero = (i_op == OP_CMP) ? (w_aa == w_bb) : (o_res == {WORD_W{1'b0}});
        o_sign = (i_op == OP_CMP) ? w_acarry : |(o_res & w_top);
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle ALU with valid/ready handshake, iterative
//                shifts/rotates and persistent zero/sign/carry flags
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WORD_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              mode,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] result,
    output logic              flag_zero,
    output logic              flag_sign,
    output logic              flag_carry,
    output logic              busy
);

    localparam int SHAMT_W = $clog2(WORD_W);

    if ((WORD_W % 2 != 0) || (WORD_W < 4)) begin : g_bad_width
        $error("seq_alu: WORD_W must be even and at least 4");
    end

    state_e             r_state;
    state_e             w_state_next;
    op_e                r_op;
    logic               r_mode;
    logic [WORD_W-1:0]  r_work;
    logic [WORD_W-1:0]  r_b;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WORD_W-1:0]  r_result;
    logic               r_zero;
    logic               r_sign;
    logic               r_carry;

    logic [SHAMT_W-1:0] w_count;
    logic               w_accept;
    logic               w_go_exec;
    logic               w_last_step;
    logic               w_commit;

    op_e                w_c_op;
    logic               w_c_mode;
    logic [WORD_W-1:0]  w_c_a;
    logic [WORD_W-1:0]  w_c_b;
    logic               w_c_shz;
    logic [WORD_W-1:0]  w_res;
    logic               w_zero;
    logic               w_sign;
    logic               w_carry;
    logic               w_carry_we;
    logic               w_flags_we;

    assign w_count     = b[SHAMT_W-1:0];
    assign w_accept    = (r_state == ST_IDLE) && in_valid;
    assign w_go_exec   = is_shift(op_e'(op)) && (w_count != '0);
    assign w_last_step = (r_state == ST_EXEC) && (r_cnt == SHAMT_W'(1));
    assign w_commit    = (w_accept && !w_go_exec) || w_last_step;

    // Core sees live inputs while idle, the latched operation while iterating
    always_comb begin
        w_c_op   = op_e'(op);
        w_c_mode = mode;
        w_c_a    = a;
        w_c_b    = b;
        w_c_shz  = (w_count == '0);
        if (r_state != ST_IDLE) begin
            w_c_op   = r_op;
            w_c_mode = r_mode;
            w_c_a    = r_work;
            w_c_b    = r_b;
            w_c_shz  = 1'b0;
        end
    end

    alu_core #(
        .WORD_W (WORD_W)
    ) u_core (
        .i_op         (w_c_op),
        .i_mode       (w_c_mode),
        .i_a          (w_c_a),
        .i_b          (w_c_b),
        .i_cin        (r_carry),
        .i_shamt_zero (w_c_shz),
        .o_res        (w_res),
        .o_zero       (w_zero),
        .o_sign       (w_sign),
        .o_carry      (w_carry),
        .o_carry_we   (w_carry_we),
        .o_flags_we   (w_flags_we)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_next = w_go_exec ? ST_EXEC : ST_DONE;
            ST_EXEC: if (r_cnt == SHAMT_W'(1)) w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latch the operation at acceptance and step the working value in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_NOP;
            r_mode <= 1'b0;
            r_work <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_op   <= op_e'(op);
            r_mode <= mode;
            r_work <= a;
            r_b    <= b;
            r_cnt  <= w_count;
        end else if (r_state == ST_EXEC) begin
            r_work <= w_res;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end

    // Result and flags are written together, only when an operation completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_sign   <= 1'b0;
            r_carry  <= 1'b0;
        end else if (w_commit) begin
            r_result <= w_res;
            if (w_flags_we) begin
                r_zero <= w_zero;
                r_sign <= w_sign;
            end
            if (w_carry_we) begin
                r_carry <= w_carry;
            end
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign result     = r_result;
    assign flag_zero  = r_zero;
    assign flag_sign  = r_sign;
    assign flag_carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Self-checking bench for seq_alu against a behavioural model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_zero;
    logic         flag_sign;
    logic         flag_carry;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Model flag state
    logic m_z = 1'b0;
    logic m_s = 1'b0;
    logic m_c = 1'b0;

    seq_alu #(.WORD_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .mode       (mode),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_sign  (flag_sign),
        .flag_carry (flag_carry),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-operation arithmetic on integers, shifts computed in one go
    function automatic void ref_op(input logic [3:0] opc, input logic md,
                                   input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic cz, input logic cs, input logic cc,
                                   output logic [W-1:0] r, output logic z,
                                   output logic s, output logic c, output int lat);
        int     aw;
        int     n;
        int     k;
        longint mask;
        longint x;
        longint y;
        longint t;
        longint res;
        logic   upd;
        aw   = md ? W : W / 2;
        mask = (longint'(1) << aw) - 1;
        x    = longint'(ia) & mask;
        y    = longint'(ib) & mask;
        n    = int'(ib[4:0]);
        k    = n % aw;
        z    = cz;
        s    = cs;
        c    = cc;
        upd  = 1'b1;
        res  = x;
        lat  = (opc >= 4'hA && opc <= 4'hD && n != 0) ? n : 0;
        case (opc)
            4'h0: res = ~x & mask;
            4'h1: res = x & y;
            4'h2: res = x | y;
            4'h3: res = x ^ y;
            4'h4: begin t = x + y;              c = t[aw];   res = t & mask; end
            4'h5: begin t = x + y + cc;         c = t[aw];   res = t & mask; end
            4'h6: begin t = x - y;              c = (t < 0); res = t & mask; end
            4'h7: begin t = x - y - cc;         c = (t < 0); res = t & mask; end
            4'h8: begin t = x + 1;              c = t[aw];   res = t & mask; end
            4'h9: begin t = x - 1;              c = (t < 0); res = t & mask; end
            4'hA: if (n != 0) begin
                res = (n >= aw) ? 0 : ((x << n) & mask);
                c   = (n <= aw) ? x[aw-n] : 1'b0;
            end
            4'hB: if (n != 0) begin
                res = x >> n;
                c   = (n <= aw) ? x[n-1] : 1'b0;
            end
            4'hC: if (n != 0) begin
                res = ((x << k) | (x >> (aw - k))) & mask;
                c   = res[0];
            end
            4'hD: if (n != 0) begin
                res = ((x >> k) | (x << (aw - k))) & mask;
                c   = res[aw-1];
            end
            4'hE: begin res = x; z = (x == y); s = (x < y); upd = 1'b0; end
            default: begin res = x; upd = 1'b0; end
        endcase
        if (upd) begin
            z = (res == 0);
            s = res[aw-1];
        end
        r = res[W-1:0];
    endfunction

    // Issue one operation, check latency, result, flags, hold stability and handshake
    task automatic run_op(input logic [3:0] opc, input logic md,
                          input logic [W-1:0] ia, input logic [W-1:0] ib, input int hold);
        logic [W-1:0] er;
        logic ez;
        logic es;
        logic ec;
        int   lat;
        int   cyc;
        ref_op(opc, md, ia, ib, m_z, m_s, m_c, er, ez, es, ec, lat);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        op       = opc;
        mode     = md;
        a        = ia;
        b        = ib;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode     = ~md;
        a        = W'($urandom);
        b        = W'($urandom);
        op       = 4'($urandom);
        cyc      = 0;
        while (out_valid !== 1'b1 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("latency op%0h", opc), cyc, lat);
        check($sformatf("result op%0h", opc), result, er);
        check($sformatf("zero op%0h", opc), flag_zero, ez);
        check($sformatf("sign op%0h", opc), flag_sign, es);
        check($sformatf("carry op%0h", opc), flag_carry, ec);
        check("busy_done", busy, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_result", result, er);
            check("hold_flags", {flag_zero, flag_sign, flag_carry}, {ez, es, ec});
            check("hold_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 1'b0);
        check("in_ready_back", in_ready, 1'b1);
        m_z = ez;
        m_s = es;
        m_c = ec;
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        mode      = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 20'h0);
        check("rst_flags", {flag_zero, flag_sign, flag_carry}, 3'b000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run_op(4'h4, 1'b1, 20'hFFFFF, 20'h00001, 0);
        run_op(4'h5, 1'b0, 20'hFF3FF, 20'h00000, 0);
        run_op(4'hC, 1'b1, 20'h80001, 20'h00004, 0);
        run_op(4'hB, 1'b0, 20'h00207, 20'h00003, 0);
        run_op(4'hE, 1'b1, 20'h00005, 20'h00009, 0);
        run_op(4'h6, 1'b1, 20'h00005, 20'h00009, 3);
        // Boundaries: zero counts, counts at/over AW, borrow from zero
        run_op(4'hA, 1'b1, 20'h12345, 20'h00000, 0);
        run_op(4'hA, 1'b0, 20'h00201, 20'h0000A, 0);
        run_op(4'hB, 1'b0, 20'h003FF, 20'h0001F, 0);
        run_op(4'hD, 1'b1, 20'h00001, 20'h00014, 0);
        run_op(4'hC, 1'b0, 20'h00301, 20'h0000B, 0);
        run_op(4'h9, 1'b0, 20'h00000, 20'h00000, 1);
        run_op(4'h7, 1'b0, 20'h00000, 20'h00001, 0);
        run_op(4'hF, 1'b1, 20'h00000, 20'h00000, 0);

        // Randomised operations
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), 1'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 2)));
        end

        // Leave flags nonzero, then abandon a long shift with reset
        run_op(4'h4, 1'b1, 20'hFFFFF, 20'h00001, 0);
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'hA;
        mode     = 1'b1;
        a        = 20'h0F0F0;
        b        = 20'h0000F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("exec_busy", busy, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_flags", {flag_zero, flag_sign, flag_carry}, 3'b000);
        check("abort_result", result, 20'h0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        m_z  = 1'b0;
        m_s  = 1'b0;
        m_c  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_result", seen, 1'b0);
        run_op(4'h5, 1'b1, 20'h00010, 20'h00020, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the single-cycle ALU circuits. It takes one operation through a valid/ready handshake and runs logic, arithmetic and compare ops in one cycle. Shifts and rotates by an arbitrary count run iteratively, one bit per cycle. It owns persistent zero/sign/carry status flags and supports full-word and half-word modes, and it sits between the decode stage and register-file writeback of the CPU.

## Interface
- `WORD_W`, default 20: datapath width. Must be even and ≥ 4. Derived localparams: `HALF_W = WORD_W/2`, `SHAMT_W = $clog2(WORD_W)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  high only in IDLE.
- `op`  in  4  opcode (see Operation).
- `mode`  in  1  1 = full word (`WORD_W` bits), 0 = half word (low `HALF_W` bits).
- `a`, `b`  in  `WORD_W`  operands. For shifts/rotates, `b[SHAMT_W-1:0]` is the count.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  `WORD_W`  registered result.
- `flag_zero`, `flag_sign`, `flag_carry`  out  1 each  registered status flags.
- `busy`  out  1  high in EXEC or DONE.

## Operation
- Active width `AW` = `WORD_W` if `mode`=1, else `HALF_W`. Operands are truncated to `AW`. `result[WORD_W-1:AW]` is always 0.
- Opcodes:
  - 0 NOT; 1 AND; 2 OR; 3 XOR.
  - 4 ADD: carry-in 0. 5 ADC: carry-in = `flag_carry`.
  - 6 SUB: a−b, carry = borrow. 7 SBC: a−b−`flag_carry`.
  - 8 INC; 9 DEC.
  - A SHL (numeric left, 0 fill); B SHR (logical right, 0 fill); C ROL; D ROR.
  - E CMP: result = a, flags from a−b.
  - F NOP: result = a, flags unchanged.
- Flags are written on the same edge the result is written:
  - zero = (active result == 0). For CMP, zero means a == b.
  - sign = result bit `AW-1`. For CMP, sign means a < b (unsigned).
  - carry = carry-out/borrow at bit `AW` for ADD/ADC/SUB/SBC/INC/DEC.
  - carry = last bit shifted out for SHL/SHR, and last bit wrapped for ROL/ROR.
  - carry is unchanged for logic ops, CMP and NOP.
- Shift/rotate with count 0: result = a, carry unchanged.
- Counts ≥ `AW` are still executed step by step. A shift then yields 0; a rotate wraps modulo `AW`.
- FSM:
  - IDLE: on `in_valid`, latch op/mode/a/b. Count 0 or a non-shift op goes to DONE; otherwise go to EXEC with counter = count.
  - EXEC: one bit per cycle; decrement the counter; at 0, go to DONE.
  - DONE: `out_valid`=1; on `out_ready`, go to IDLE.
- `mode` is latched at acceptance; changes mid-operation are ignored.

## Timing
- Reset values: state IDLE, `result`=0, all flags 0, `out_valid`=0, `busy`=0, `in_ready`=1.
- Acceptance at edge T. Non-shift ops, or count 0: `out_valid` rises at T+1. Shift by n: `out_valid` rises at T+1+n.
- `result` and flags are stable while `out_valid`=1 and `out_ready`=0.
- No new acceptance in the cycle `out_valid` drops. `in_ready` rises the cycle after the DONE handshake, so peak throughput is one op per 2 cycles.
- `rst` asserted at any time, including mid-EXEC, abandons the operation immediately. No result is produced.

## Structure
- Shared package `alu_pkg` holds:
  - `op_e` opcode enum with the encodings above;
  - `state_e` {IDLE, EXEC, DONE}.
- Sub-module `alu_core`: combinational single-cycle datapath (logic, add/sub, compare, single-bit shift/rotate step), parametrised by `WORD_W`. `seq_alu` holds the FSM, counter, operand/result registers and flags.

## Test plan
- ADD, `mode`=1, a=0xFFFFF, b=0x00001 -> `result`=0x00000, zero=1, carry=1, sign=0, `out_valid` at T+1.
- Then ADC, `mode`=0, a=0xFF3FF, b=0 (carry=1 from the previous op) -> `result`=0x00000, carry=1, zero=1, upper bits 0.
- ROL, `mode`=1, a=0x80001, b=4 -> `result`=0x00018, carry=0, `out_valid` at T+5.
- SHR, `mode`=0, a=0x00207, b=3 -> `result`=0x00040, carry=1, sign=0, `out_valid` at T+4.
- CMP a=0x00005, b=0x00009 -> `result`=0x00005, zero=0, sign=1, carry unchanged. SUB with the same operands -> 0xFFFFC, carry=1, sign=1.
- Hold `out_ready`=0 for 3 cycles -> `result`/flags stable, `in_ready`=0. Start SHL by 15 and assert `rst` at cycle T+3 -> `out_valid`=0, flags 0, `in_ready`=1, with no result ever presented.
